filtre_hakem: RTL
=================

# filtre_hakem

Round-robin arbiter and sequencer that shares one `davranis_filtreleyici` filter instance between two requesters, A and B. Each requester submits a 3-bit raw code (`saf`). The block grants one request at a time and drives the code onto the filter input. It waits a programmable settle time, then captures the 5-bit filtered result (`filtre`) and holds it until the owner acknowledges it. The block sits between the requesters and the filter; the filter itself stays outside it.

## Interface
- `SETTLE_CYC`, default 2: cycles the code is held on the filter before capture. Legal range is 1..15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_a`  in  1  requester A request; held until `gnt_a`.
- `code_a`  in  3  requester A raw code; stable while `req_a` is high.
- `req_b`  in  1  requester B request; held until `gnt_b`.
- `code_b`  in  3  requester B raw code; stable while `req_b` is high.
- `gnt_a`  out  1  one-cycle accept pulse to A.
- `gnt_b`  out  1  one-cycle accept pulse to B.
- `saf_o`  out  3  code driven to the filter input.
- `filtre_i`  in  5  filter output, sampled at capture.
- `sonuc`  out  5  captured filter result.
- `sonuc_gecerli`  out  1  result valid; held until acknowledged.
- `sonuc_sahip`  out  1  owner of `sonuc`: 0 = A, 1 = B.
- `sonuc_al`  in  1  result acknowledge from the owner.
- `mesgul`  out  1  high whenever the state is not IDLE.

## Operation
- The state machine has three states: IDLE, SETTLE, RESP.
- **IDLE:**
  - If `req_a` or `req_b` is high at an edge, the block picks a winner. It latches the winner's code into `saf_o`, sets the owner, pulses the matching `gnt_*` for one cycle, loads the counter with `SETTLE_CYC`, and moves to SETTLE.
  - If no request is high, it stays in IDLE and all outputs hold.
- **Arbitration:**
  - A one-bit priority pointer decides ties. Its reset value is A.
  - If only one requester is asserting, that requester wins regardless of the pointer.
  - If both are asserting, the requester the pointer names wins.
  - After every grant the pointer moves to the other requester.
- **SETTLE:**
  - The counter decrements on each edge.
  - At the edge where the counter equals 1: `filtre_i` is copied into `sonuc`, `sonuc_gecerli` is set to 1, and the state moves to RESP.
- **RESP:**
  - `sonuc`, `sonuc_sahip` and `sonuc_gecerli` hold.
  - At an edge with `sonuc_al` = 1: `sonuc_gecerli` goes to 0 and the state moves to IDLE.
  - No new grant is issued at that same edge.
- `sonuc_al` is ignored in IDLE and SETTLE.
- If a request drops before it is granted, no grant is issued and no state changes.
- A request that arrives in SETTLE or RESP waits. It is arbitrated on the first IDLE edge.
- `saf_o` and `sonuc` keep their last values until the next grant or capture. They are not cleared by ack.
- **Reset values** (immediate on `rst_n` low, including mid-operation):
  - state = IDLE, pointer = A, counter = 0.
  - `saf_o` = 0, `sonuc` = 0, `sonuc_sahip` = 0.
  - `sonuc_gecerli` = 0, `gnt_a` = `gnt_b` = 0, `mesgul` = 0.
  - An in-flight request is dropped with no result.

## Timing
- The grant is registered. `gnt_x` and the new `saf_o` appear after edge E0, the edge at which the request was sampled in IDLE.
- The capture edge is E(`SETTLE_CYC`). `sonuc_gecerli` is high from that edge on, so latency from the request edge to valid is `SETTLE_CYC` cycles. With the default, that is 2.
- The filter is combinational. `filtre_i` must be settled `SETTLE_CYC` cycles after `saf_o` changes.
- Ack at edge Ea gives IDLE after Ea. The earliest next grant is at Ea+1.
- Peak throughput is one transaction per `SETTLE_CYC` + 2 cycles.
- The grant pulse is exactly one cycle wide and never asserts for both requesters in the same cycle.

## Test plan
- **Reset:** hold `rst_n` = 0 with requests active, then release. All outputs read 0 and `mesgul` = 0 until the first sampled request.
- **Single A request:** `req_a` = 1, `code_a` = 5, filter modelled as a fixed mapping, ack held high.
  - `gnt_a` pulses after E0 and `saf_o` = 5.
  - `sonuc` = map(5), `sonuc_gecerli` = 1 and `sonuc_sahip` = 0 after E2.
  - `sonuc_gecerli` drops one edge after ack.
- **Fairness:** hold `req_a` and `req_b` high for codes 7, 6, 5, 4 with immediate ack. Grants alternate A, B, A, B, and `sonuc_sahip` alternates 0, 1, 0, 1.
- **Back-pressure:** hold `sonuc_al` = 0 for 10 cycles after valid, with `req_b` pending. `sonuc` is stable, no `gnt_b` is issued, and `gnt_b` appears one edge after IDLE is re-entered.
- **Reset mid-operation:** assert `rst_n` low during SETTLE. After release: no valid, `sonuc` = 0, pointer = A (a simultaneous request from both is granted to A).
- **SETTLE_CYC sweep:** with `SETTLE_CYC` = 1 and = 4, sweep codes 7 down to 0. Valid appears exactly 1 and 4 edges after the grant edge respectively, and each `sonuc` equals map(code).

Source files
------------

// File: rtl/filtre_hakem.sv
// rtl/filtre_hakem.sv - round-robin arbiter/sequencer sharing one external filter between two requesters
module filtre_hakem #(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic [2:0] code_a,
    input  logic       req_b,
    input  logic [2:0] code_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic [2:0] saf_o,
    input  logic [4:0] filtre_i,
    output logic [4:0] sonuc,
    output logic       sonuc_gecerli,
    output logic       sonuc_sahip,
    input  logic       sonuc_al,
    output logic       mesgul
);

    // Settle count as loaded into the 4-bit down counter (legal range 1..15).
    localparam logic [3:0] SETTLE_YUK = 4'(SETTLE_CYC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } durum_t;

    durum_t     durum;
    durum_t     durum_next;
    logic       isaretci;      // tie-break pointer: 0 = A has priority, 1 = B
    logic [3:0] sayac;         // remaining settle cycles
    logic       talep_var;     // at least one requester asserting
    logic       kazanan_b;     // 1 when B wins this arbitration round
    logic       yakala;        // capture edge: last settle cycle

    // Arbitration: a lone requester always wins; on a tie the pointer decides.
    always_comb begin
        talep_var = req_a | req_b;
        kazanan_b = req_b & (~req_a | isaretci);
        yakala    = (durum == SETTLE) && (sayac <= 4'd1);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum <= IDLE;
        end else begin
            durum <= durum_next;
        end
    end

    // Next-state logic: grant from IDLE, capture ends SETTLE, ack ends RESP.
    always_comb begin
        durum_next = durum;
        case (durum)
            IDLE: begin
                if (talep_var) begin
                    durum_next = SETTLE;
                end
            end
            SETTLE: begin
                if (yakala) begin
                    durum_next = RESP;
                end
            end
            RESP: begin
                if (sonuc_al) begin
                    durum_next = IDLE;
                end
            end
            default: durum_next = IDLE;
        endcase
    end

    // Datapath: grant pulses, code latch, pointer, settle counter, result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_a         <= 1'b0;
            gnt_b         <= 1'b0;
            saf_o         <= 3'd0;
            sonuc         <= 5'd0;
            sonuc_gecerli <= 1'b0;
            sonuc_sahip   <= 1'b0;
            isaretci      <= 1'b0;
            sayac         <= 4'd0;
        end else begin
            gnt_a <= 1'b0;
            gnt_b <= 1'b0;
            case (durum)
                IDLE: begin
                    if (talep_var) begin
                        saf_o       <= kazanan_b ? code_b : code_a;
                        sonuc_sahip <= kazanan_b;
                        gnt_a       <= ~kazanan_b;
                        gnt_b       <= kazanan_b;
                        sayac       <= SETTLE_YUK;
                        // Next tie goes to whoever did not just win.
                        isaretci    <= ~kazanan_b;
                    end
                end
                SETTLE: begin
                    sayac <= sayac - 4'd1;
                    if (yakala) begin
                        sonuc         <= filtre_i;
                        sonuc_gecerli <= 1'b1;
                    end
                end
                RESP: begin
                    if (sonuc_al) begin
                        sonuc_gecerli <= 1'b0;
                    end
                end
                default: begin
                    sonuc_gecerli <= 1'b0;
                end
            endcase
        end
    end

    // Busy whenever a transaction is in flight.
    always_comb begin
        mesgul = (durum != IDLE);
    end

endmodule
